// File: rtl/rpn_pkg.sv
// Shared types and opcode rules for the RPN stack engine.
package rpn_pkg;

    typedef enum logic [3:0] {
        OP_PUSH = 4'd0,
        OP_GT   = 4'd1,
        OP_NEG  = 4'd2,
        OP_ADD  = 4'd3,
        OP_MUL  = 4'd4,
        OP_SWAP = 4'd5,
        OP_LOAD = 4'd6,
        OP_POP  = 4'd7,
        OP_DUP  = 4'd8,
        OP_OVER = 4'd9,
        OP_CLR  = 4'd10
    } op_t;

    typedef enum logic [1:0] {
        ERR_OVF     = 2'd0,
        ERR_UNF     = 2'd1,
        ERR_RANGE   = 2'd2,
        ERR_ILLEGAL = 2'd3
    } err_t;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    localparam int MIN_D_GT   = 1;
    localparam int MIN_D_NEG  = 1;
    localparam int MIN_D_ADD  = 2;
    localparam int MIN_D_MUL  = 2;
    localparam int MIN_D_SWAP = 2;
    localparam int MIN_D_LOAD = 2;
    localparam int MIN_D_POP  = 1;
    localparam int MIN_D_DUP  = 1;
    localparam int MIN_D_OVER = 2;

    function automatic int min_depth(input op_t op);
        case (op)
            OP_GT:   return MIN_D_GT;
            OP_NEG:  return MIN_D_NEG;
            OP_ADD:  return MIN_D_ADD;
            OP_MUL:  return MIN_D_MUL;
            OP_SWAP: return MIN_D_SWAP;
            OP_LOAD: return MIN_D_LOAD;
            OP_POP:  return MIN_D_POP;
            OP_DUP:  return MIN_D_DUP;
            OP_OVER: return MIN_D_OVER;
            default: return 0;
        endcase
    endfunction

    function automatic logic grows(input op_t op);
        return (op == OP_PUSH) || (op == OP_DUP) || (op == OP_OVER);
    endfunction

endpackage

// File: rtl/rpn_stack_ram.sv
// Below-top stack storage: asynchronous read, synchronous write.
module rpn_stack_ram #(
    parameter int W      = 16,
    parameter int D_LOG2 = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [D_LOG2-1:0] waddr,
    input  logic [W-1:0]      wdata,
    input  logic [D_LOG2-1:0] raddr,
    output logic [W-1:0]      rdata
);

    logic [W-1:0] mem [2**D_LOG2];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/rpn_stack_engine.sv
// RPN stack engine: registered top, RAM-backed remainder, iterative multiplier.
// Define RPN_SAT_EN for saturating ADD/MUL/NEG instead of wrapping.
module rpn_stack_engine
    import rpn_pkg::*;
#(
    parameter int W      = 16,
    parameter int D_LOG2 = 4
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [W-1:0]      cmd_data,
    output logic [W-1:0]      top,
    output logic [D_LOG2:0]   depth,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam int DW = D_LOG2 + 1;
    localparam logic [DW-1:0] CAP_D = DW'(2**D_LOG2);
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
`ifdef RPN_SAT_EN
    localparam int PW = 2 * W;
    localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [PW-1:0] PMAX = {{(PW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [PW-1:0] PMIN = {{(PW-W+1){1'b1}}, {(W-1){1'b0}}};
`else
    localparam int PW = W;
`endif

    function automatic logic [W-1:0] sat_add(input logic signed [W-1:0] a,
                                             input logic signed [W-1:0] b);
`ifdef RPN_SAT_EN
        logic signed [W:0] s;
        s = {a[W-1], a} + {b[W-1], b};
        if (s[W] != s[W-1]) return s[W] ? MINV : MAXV;
        return s[W-1:0];
`else
        return a + b;
`endif
    endfunction

    function automatic logic [W-1:0] sat_neg(input logic signed [W-1:0] a);
`ifdef RPN_SAT_EN
        if (a == MINV) return MAXV;
`endif
        return -a;
    endfunction

    function automatic logic [W-1:0] mul_res(input logic signed [PW-1:0] p);
`ifdef RPN_SAT_EN
        if (p > PMAX) return MAXV;
        if (p < PMIN) return MINV;
        return p[W-1:0];
`else
        return p;
`endif
    endfunction

    state_t                state;
    err_t                  err_code_r;
    logic [CW-1:0]         cnt;
    logic signed [W-1:0]   top_s;
    logic signed [W-1:0]   second;
    logic [W-1:0]          rdata;
    logic [DW-1:0]         dm1;
    logic [D_LOG2-1:0]     dm1_a, dm2_a, ld_a, raddr, waddr;
    logic                  accept, bad, we, start_mul;
    err_t                  bad_code;
    op_t                   op;
    logic [W-1:0]          nxt_top;
    logic [DW-1:0]         nxt_depth;
    logic signed [PW-1:0]  acc_p0, mcand_p0, addend, acc_nxt;
    logic [W-1:0]          mplier_p0;

    assign cmd_ready = (state == IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign op        = op_t'(cmd_op);
    assign top_s     = top;
    assign err_code  = err_code_r;
    assign second    = rdata;

    // Element k>=1 lives at mem[depth-1-k]; addresses wrap modulo capacity.
    assign dm1   = depth - DW'(1);
    assign dm1_a = depth[D_LOG2-1:0] - D_LOG2'(1);
    assign dm2_a = depth[D_LOG2-1:0] - D_LOG2'(2);
    assign ld_a  = dm2_a - top[D_LOG2-1:0];
    assign raddr = (op == OP_LOAD) ? ld_a : dm2_a;

    rpn_stack_ram #(.W(W), .D_LOG2(D_LOG2)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (top),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_comb begin
        bad       = 1'b0;
        bad_code  = ERR_OVF;
        nxt_top   = top;
        nxt_depth = depth;
        we        = 1'b0;
        waddr     = dm1_a;
        if (cmd_op > 4'd10) begin
            bad      = 1'b1;
            bad_code = ERR_ILLEGAL;
        end else if (depth < DW'(min_depth(op))) begin
            bad      = 1'b1;
            bad_code = ERR_UNF;
        end else if (grows(op) && depth == CAP_D) begin
            bad      = 1'b1;
            bad_code = ERR_OVF;
        end else if (op == OP_LOAD && !(top < W'(dm1))) begin
            bad      = 1'b1;
            bad_code = ERR_RANGE;
        end
        case (op)
            OP_PUSH: begin
                nxt_top   = cmd_data;
                nxt_depth = depth + DW'(1);
                we        = (depth != '0);
            end
            OP_GT:   nxt_top = {{(W-1){1'b0}}, (!top[W-1] && top != '0)};
            OP_NEG:  nxt_top = sat_neg(top_s);
            OP_ADD: begin
                nxt_top   = sat_add(second, top_s);
                nxt_depth = dm1;
            end
            OP_SWAP: begin
                nxt_top = second;
                we      = 1'b1;
                waddr   = dm2_a;
            end
            OP_LOAD: nxt_top = second;
            OP_POP: begin
                nxt_top   = (depth == DW'(1)) ? '0 : second;
                nxt_depth = dm1;
            end
            OP_DUP: begin
                nxt_depth = depth + DW'(1);
                we        = 1'b1;
            end
            OP_OVER: begin
                nxt_top   = second;
                nxt_depth = depth + DW'(1);
                we        = 1'b1;
            end
            default: ;
        endcase
        if (!accept || bad) we = 1'b0;
        start_mul = accept && !bad && (op == OP_MUL);
    end

    // Signed shift-add: the last multiplier bit carries negative weight.
    always_comb begin
        addend  = mplier_p0[0] ? mcand_p0 : '0;
        acc_nxt = (cnt == CNT_LAST) ? acc_p0 - addend : acc_p0 + addend;
    end

    always_ff @(posedge clk) begin
        if (start_mul) begin
            acc_p0    <= '0;
            mcand_p0  <= PW'(top_s);
            mplier_p0 <= second;
        end else if (state == MUL) begin
            acc_p0    <= acc_nxt;
            mcand_p0  <= mcand_p0 <<< 1;
            mplier_p0 <= mplier_p0 >> 1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= IDLE;
            top        <= '0;
            depth      <= '0;
            err        <= 1'b0;
            err_code_r <= ERR_OVF;
            cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (bad) begin
                            err <= 1'b1;
                            if (!err) err_code_r <= bad_code;
                        end else if (op == OP_CLR) begin
                            err        <= 1'b0;
                            err_code_r <= ERR_OVF;
                        end else if (op == OP_MUL) begin
                            state <= MUL;
                            cnt   <= '0;
                        end else begin
                            top   <= nxt_top;
                            depth <= nxt_depth;
                        end
                    end
                end
                MUL: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CNT_LAST) begin
                        top   <= mul_res(acc_nxt);
                        depth <= dm1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rpn_stack_engine.sv
// Randomised and directed bench for rpn_stack_engine against a queue-based stack model.
module tb_rpn_stack_engine;

    localparam int W      = 16;
    localparam int D_LOG2 = 2;
    localparam int CAP    = 4;

    logic            clk = 1'b0;
    logic            nrst = 1'b0;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [3:0]      cmd_op = 4'd0;
    logic [W-1:0]    cmd_data = '0;
    logic [W-1:0]    top;
    logic [D_LOG2:0] depth;
    logic            err;
    logic [1:0]      err_code;

    int n_vec = 0;
    int n_bad = 0;

    logic [W-1:0] m_st[$];
    logic         m_err;
    logic [1:0]   m_code;
    int           last_busy;

    rpn_stack_engine #(.W(W), .D_LOG2(D_LOG2)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .top       (top),
        .depth     (depth),
        .err       (err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] clamp(input int v);
`ifdef RPN_SAT_EN
        if (v > 32767) return 16'h7FFF;
        if (v < -32768) return 16'h8000;
`endif
        return v[W-1:0];
    endfunction

    task automatic model(input logic [3:0] op, input logic [W-1:0] d, output bit bad);
        int n;
        int code;
        int i;
        logic [W-1:0] a, b;
        n = m_st.size();
        bad = 0;
        code = 0;
        case (op)
            4'd0: if (n >= CAP) begin bad = 1; code = 0; end
                  else m_st.push_front(d);
            4'd1: if (n < 1) begin bad = 1; code = 1; end
                  else m_st[0] = ($signed(m_st[0]) > 16'sd0) ? 16'd1 : 16'd0;
            4'd2: if (n < 1) begin bad = 1; code = 1; end
                  else begin
`ifdef RPN_SAT_EN
                      if (m_st[0] == 16'h8000) m_st[0] = 16'h7FFF;
                      else m_st[0] = -m_st[0];
`else
                      m_st[0] = -m_st[0];
`endif
                  end
            4'd3, 4'd4: if (n < 2) begin bad = 1; code = 1; end
                  else begin
                      a = m_st.pop_front();
                      b = m_st.pop_front();
                      if (op == 4'd3) m_st.push_front(clamp(int'($signed(a)) + int'($signed(b))));
                      else            m_st.push_front(clamp(int'($signed(a)) * int'($signed(b))));
                  end
            4'd5: if (n < 2) begin bad = 1; code = 1; end
                  else begin a = m_st[0]; m_st[0] = m_st[1]; m_st[1] = a; end
            4'd6: if (n < 2) begin bad = 1; code = 1; end
                  else begin
                      i = int'(m_st[0]);
                      if (i >= n - 1) begin bad = 1; code = 2; end
                      else m_st[0] = m_st[i+1];
                  end
            4'd7: if (n < 1) begin bad = 1; code = 1; end
                  else void'(m_st.pop_front());
            4'd8: if (n < 1) begin bad = 1; code = 1; end
                  else if (n >= CAP) begin bad = 1; code = 0; end
                  else m_st.push_front(m_st[0]);
            4'd9: if (n < 2) begin bad = 1; code = 1; end
                  else if (n >= CAP) begin bad = 1; code = 0; end
                  else m_st.push_front(m_st[1]);
            4'd10: begin m_err = 0; m_code = 0; end
            default: begin bad = 1; code = 3; end
        endcase
        if (bad) begin
            if (!m_err) m_code = code[1:0];
            m_err = 1;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "/top"}, 32'(top), (m_st.size() > 0) ? 32'(m_st[0]) : 32'd0);
        check({tag, "/depth"}, 32'(depth), 32'(m_st.size()));
        check({tag, "/err"}, 32'(err), 32'(m_err));
        check({tag, "/code"}, 32'(err_code), 32'(m_code));
        check({tag, "/ready"}, 32'(cmd_ready), 32'd1);
    endtask

    task automatic do_cmd(input string tag, input logic [3:0] op, input logic [W-1:0] d);
        bit bad;
        int busy;
        logic [W-1:0] pre_top;
        pre_top = top;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        @(posedge clk);
        #1;
        model(op, d, bad);
        busy = 0;
        if (!cmd_ready) begin
            cmd_op   = 4'd0;
            cmd_data = 16'h1234;
            while (!cmd_ready && busy < 100) begin
                busy++;
                if (busy == 8) check({tag, "/mulhold"}, 32'(top), 32'(pre_top));
                @(posedge clk);
                #1;
            end
        end
        cmd_valid = 1'b0;
        last_busy = busy;
        check({tag, "/busy"}, 32'(busy), (op == 4'd4 && !bad) ? W : 0);
        check_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        nrst = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        m_st.delete();
        m_err = 0;
        m_code = 0;
        #1;
        check_all("reset");
    endtask

    initial begin
        logic [3:0] op;
        logic [W-1:0] d;
        int r;
        m_err = 0;
        m_code = 0;
        do_reset();

        do_cmd("t1a", 4'd0, 16'd3);
        do_cmd("t1b", 4'd0, 16'd4);
        do_cmd("t1c", 4'd3, 16'd0);
        check("t1_top", 32'(top), 32'd7);

        do_reset();
        do_cmd("t2a", 4'd0, 16'hFFFD);
        do_cmd("t2b", 4'd0, 16'd5);
        do_cmd("t2c", 4'd4, 16'd0);
        check("t2_top", 32'(top), 32'hFFF1);
        check("t2_depth", 32'(depth), 32'd1);

        do_reset();
        for (int k = 1; k <= 5; k++) do_cmd("t3push", 4'd0, 16'(k));
        check("t3_code", 32'(err_code), 32'd0);
        check("t3_top", 32'(top), 32'd4);
        do_cmd("t3add", 4'd3, 16'd0);
        check("t3_add", 32'(top), 32'd7);
        do_cmd("t3clr", 4'd10, 16'd0);
        check("t3_err", 32'(err), 32'd0);

        do_reset();
        do_cmd("t4add", 4'd3, 16'd0);
        check("t4_code", 32'(err_code), 32'd1);
        do_cmd("t4ill", 4'd13, 16'd0);
        check("t4_code2", 32'(err_code), 32'd1);

        do_reset();
        do_cmd("t5a", 4'd0, 16'd10);
        do_cmd("t5b", 4'd0, 16'd20);
        do_cmd("t5c", 4'd0, 16'd30);
        do_cmd("t5d", 4'd0, 16'd1);
        do_cmd("t5ld", 4'd6, 16'd0);
        check("t5_top", 32'(top), 32'd20);
        do_cmd("t5p1", 4'd7, 16'd0);
        do_cmd("t5p2", 4'd7, 16'd0);
        do_cmd("t5e", 4'd0, 16'd3);
        do_cmd("t5ld2", 4'd6, 16'd0);
        check("t5_code", 32'(err_code), 32'd2);
        check("t5_top2", 32'(top), 32'd3);

        do_reset();
        do_cmd("t6a", 4'd0, 16'h7FFF);
        do_cmd("t6b", 4'd0, 16'd1);
        do_cmd("t6c", 4'd3, 16'd0);
`ifdef RPN_SAT_EN
        check("t6_add", 32'(top), 32'h7FFF);
`else
        check("t6_add", 32'(top), 32'h8000);
`endif
        do_cmd("t6d", 4'd0, 16'd2);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 4'd4;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("t6_busy", 32'(cmd_ready), 32'd0);
        repeat (4) @(posedge clk);
        #3;
        nrst = 1'b0;
        #1;
        check("t6_rst_top", 32'(top), 32'd0);
        check("t6_rst_depth", 32'(depth), 32'd0);
        check("t6_rst_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        nrst = 1'b1;
        m_st.delete();
        m_err = 0;
        m_code = 0;
        @(posedge clk);
        #1;
        check_all("t6post");

        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 99);
            if (r < 30)      op = 4'd0;
            else if (r < 34) op = 4'd10;
            else if (r < 38) op = 4'($urandom_range(11, 15));
            else             op = 4'($urandom_range(1, 9));
            d = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 3)) : 16'($urandom);
            do_cmd("rand", op, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
